fft_frame_buffer: RTL and testbench

//  Single-clock, parametrised successor to the CODEC->FFT sample buffer.

---
 rtl/fftbuf_pkg.sv | 19 +
 rtl/fft_frame_ram.sv | 20 ++
 rtl/fft_frame_buffer.sv | 98 +++++++++
 tb/tb_fft_frame_buffer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fftbuf_pkg.sv
// fftbuf_pkg: shared read-FSM state, address-width helpers and bit reversal for the frame buffer
package fftbuf_pkg;
  typedef enum logic {IDLE, BURST} rd_state_t;
  function automatic int idx_w(input int frame_len);
    return $clog2(frame_len);
  endfunction
  function automatic int slot_w(input int num_frames);
    return $clog2(num_frames);
  endfunction
  function automatic int addr_w(input int frame_len, input int num_frames);
    return idx_w(frame_len) + slot_w(num_frames);
  endfunction
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = idx[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_frame_ram.sv
// fft_frame_ram: simple dual-port frame RAM, one write port, registered read port with enable
module fft_frame_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/fft_frame_buffer.sv
// fft_frame_buffer: codec-to-FFT frame buffer with prefetching stream output; FFTBUF_BITREV_EN selects bit-reversed readout
module fft_frame_buffer
  import fftbuf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAME_LEN = 64,
  parameter int NUM_FRAMES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              DVI,
  input  logic [DATA_W-1:0]                 dataIn,
  output logic                              DVO,
  input  logic                              rdy,
  output logic [DATA_W-1:0]                 dataOut,
  output logic                              sop,
  output logic                              eop,
  output logic [$clog2(NUM_FRAMES+1)-1:0]   frames_ready,
  output logic                              overflow
);
  localparam int IDX_W = idx_w(FRAME_LEN);
  localparam int SLOT_W = slot_w(NUM_FRAMES);
  localparam int ADDR_W = addr_w(FRAME_LEN, NUM_FRAMES);
  localparam int FR_W = $clog2(NUM_FRAMES + 1);
  localparam logic [FR_W-1:0] FULL = FR_W'(NUM_FRAMES);
  rd_state_t state;
  logic [IDX_W-1:0] wr_idx, rd_idx, rd_addr_idx;
  logic [SLOT_W-1:0] wr_slot, rd_slot;
  logic [DATA_W-1:0] ram_q;
  logic accept, commit, out_en, eop_xfer, room, avail, issue, last;
  logic rv, s1_sop, s1_eop, pend;
  assign accept = DVI && frames_ready < FULL;
  assign commit = accept && &wr_idx;
  assign out_en = !DVO || rdy;
  assign eop_xfer = DVO && rdy && eop;
  assign room = !rv || out_en;
  assign avail = frames_ready > FR_W'(pend);
  assign issue = room && (state == BURST || avail);
  assign last = &rd_idx;
`ifdef FFTBUF_BITREV_EN
  assign rd_addr_idx = IDX_W'(bitrev(32'(rd_idx), IDX_W));
`else
  assign rd_addr_idx = rd_idx;
`endif
  fft_frame_ram #(.DATA_W(DATA_W), .DEPTH(NUM_FRAMES * FRAME_LEN), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .we(accept),
    .waddr({wr_slot, wr_idx}),
    .wdata(dataIn),
    .re(issue),
    .raddr({rd_slot, rd_addr_idx}),
    .rdata(ram_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx <= '0;
      wr_slot <= '0;
      frames_ready <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_idx <= wr_idx + 1'b1;
      if (commit) wr_slot <= wr_slot + 1'b1;
      frames_ready <= frames_ready + FR_W'(commit) - FR_W'(eop_xfer);
      overflow <= overflow | (DVI && !accept);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rd_idx <= '0;
      rd_slot <= '0;
      pend <= 1'b0;
      rv <= 1'b0;
      s1_sop <= 1'b0;
      s1_eop <= 1'b0;
      DVO <= 1'b0;
      sop <= 1'b0;
      eop <= 1'b0;
      dataOut <= '0;
    end else begin
      if (issue) begin
        rd_idx <= rd_idx + 1'b1;
        s1_sop <= rd_idx == '0;
        s1_eop <= last;
        if (last) rd_slot <= rd_slot + 1'b1;
        state <= (!last || frames_ready > FR_W'(1) || commit) ? BURST : IDLE;
      end
      rv <= issue || (rv && !out_en);
      pend <= (issue && last) || (pend && !eop_xfer);
      if (out_en) begin
        DVO <= rv;
        sop <= rv && s1_sop;
        eop <= rv && s1_eop;
        if (rv) dataOut <= ram_q;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_buffer.sv
// tb_fft_frame_buffer: scoreboard bench for fft_frame_buffer (FRAME_LEN=8, NUM_FRAMES=2)
module tb_fft_frame_buffer;
  logic clk = 0, rst = 1, DVI = 0, rdy = 0;
  logic DVO, sop, eop, overflow;
  logic [15:0] dataIn = '0, dataOut;
  logic [1:0] frames_ready;
  logic [17:0] sb[$];
  logic [17:0] exp;
  int checks = 0, failures = 0;
`ifdef FFTBUF_BITREV_EN
  int perm[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
  int perm[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
  always #5 clk = ~clk;
  fft_frame_buffer #(.DATA_W(16), .FRAME_LEN(8), .NUM_FRAMES(2)) dut (
    .clk(clk),
    .rst(rst),
    .DVI(DVI),
    .dataIn(dataIn),
    .DVO(DVO),
    .rdy(rdy),
    .dataOut(dataOut),
    .sop(sop),
    .eop(eop),
    .frames_ready(frames_ready),
    .overflow(overflow)
  );
  task automatic push_frame(input logic [15:0] base);
    for (int j = 0; j < 8; j++) sb.push_back({j == 0, j == 7, base + 16'(perm[j])});
  endtask
  task automatic write_frame(input logic [15:0] base);
    push_frame(base);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      DVI = 1;
      dataIn = base + 16'(i);
    end
  endtask
  task automatic test_reset;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      DVI = !DVI;
      dataIn = 16'hA5A0 + 16'(i);
    end
    @(negedge clk);
    checks++;
    if (DVO !== 1'b0) begin failures++; $display("FAIL reset_dvo got %b expected 0", DVO); end
    checks++;
    if (frames_ready !== 2'd0) begin failures++; $display("FAIL reset_frames_ready got %0d expected 0", frames_ready); end
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got %b expected 0", overflow); end
    rst = 0;
    DVI = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (DVO !== 1'b0 || frames_ready !== 2'd0) begin
      failures++;
      $display("FAIL reset_nothing_stored got DVO=%b frames_ready=%0d expected 0/0", DVO, frames_ready);
    end
  endtask
  task automatic test_basic;
    int k;
    rdy = 1;
    write_frame(16'h0001);
    k = 0;
    do begin
      @(negedge clk);
      DVI = 0;
      k++;
      if (k == 1) begin
        checks++;
        if (frames_ready !== 2'd1) begin failures++; $display("FAIL basic_frames_ready got %0d expected 1", frames_ready); end
      end
    end while (!DVO && k < 10);
    checks++;
    if (k != 3) begin failures++; $display("FAIL basic_latency got %0d cycles expected 2 after commit", k - 1); end
    for (int c = 0; c < 20 && sb.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (DVO !== 1'b1) begin
        failures++;
        $display("FAIL basic_stream cycle %0d DVO=%b expected 1", c, DVO);
      end else begin
        exp = sb.pop_front();
        if ({sop, eop, dataOut} !== exp) begin
          failures++;
          $display("FAIL basic_data got sop=%b eop=%b data=%h expected %h", sop, eop, dataOut, exp);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL basic_count got %0d left expected 0", sb.size()); end
    @(negedge clk);
    checks++;
    if (DVO !== 1'b0 || frames_ready !== 2'd0) begin
      failures++;
      $display("FAIL basic_done got DVO=%b frames_ready=%0d expected 0/0", DVO, frames_ready);
    end
  endtask
  task automatic test_backpressure;
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    logic [18:0] held;
    logic stalled;
    stalled = 0;
    held = '0;
    rdy = 0;
    write_frame(16'h0020);
    write_frame(16'h0028);
    @(negedge clk);
    DVI = 0;
    for (int c = 0; c < 120 && sb.size() > 0; c++) begin
      if (stalled) begin
        checks++;
        if ({DVO, sop, eop, dataOut} !== held) begin
          failures++;
          $display("FAIL bp_hold got %h expected %h", {DVO, sop, eop, dataOut}, held);
        end
      end
      rdy = pat[c % 6] != 0;
      if (DVO && rdy) begin
        exp = sb.pop_front();
        checks++;
        if ({sop, eop, dataOut} !== exp) begin
          failures++;
          $display("FAIL bp_data got sop=%b eop=%b data=%h expected %h", sop, eop, dataOut, exp);
        end
      end
      held = {DVO, sop, eop, dataOut};
      stalled = DVO && !rdy;
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL bp_count got %0d left expected 0", sb.size()); end
    checks++;
    if (DVO !== 1'b0 || frames_ready !== 2'd0) begin
      failures++;
      $display("FAIL bp_no_duplicate got DVO=%b frames_ready=%0d expected 0/0", DVO, frames_ready);
    end
  endtask
  task automatic test_overflow;
    rdy = 0;
    push_frame(16'h0001);
    push_frame(16'h0009);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 16) begin
        checks++;
        if (frames_ready !== 2'd2) begin failures++; $display("FAIL ovf_full got %0d expected 2", frames_ready); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_early got %b expected 0", overflow); end
      end
      if (i == 17) begin
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got %b expected 1", overflow); end
      end
      DVI = 1;
      dataIn = 16'(i + 1);
    end
    @(negedge clk);
    DVI = 0;
    rdy = 1;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (DVO !== 1'b1) begin
        failures++;
        $display("FAIL ovf_bubble cycle %0d DVO=%b expected 1", c, DVO);
      end else begin
        exp = sb.pop_front();
        if ({sop, eop, dataOut} !== exp) begin
          failures++;
          $display("FAIL ovf_data got sop=%b eop=%b data=%h expected %h", sop, eop, dataOut, exp);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL ovf_count got %0d left expected 0", sb.size()); end
    @(negedge clk);
    checks++;
    if (DVO !== 1'b0 || frames_ready !== 2'd0) begin
      failures++;
      $display("FAIL ovf_exact16 got DVO=%b frames_ready=%0d expected 0/0", DVO, frames_ready);
    end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got %b expected 1", overflow); end
  endtask
  task automatic test_bitrev_order;
    rdy = 1;
    write_frame(16'h0000);
    @(negedge clk);
    DVI = 0;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (DVO && rdy) begin
        exp = sb.pop_front();
        checks++;
        if ({sop, eop, dataOut} !== exp) begin
          failures++;
          $display("FAIL order_data got sop=%b eop=%b data=%h expected %h", sop, eop, dataOut, exp);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL order_count got %0d left expected 0", sb.size()); end
  endtask
  task automatic test_reset_midburst;
    int n;
    rdy = 1;
    write_frame(16'h0050);
    @(negedge clk);
    DVI = 0;
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      if (DVO && rdy) begin
        exp = sb.pop_front();
        checks++;
        if ({sop, eop, dataOut} !== exp) begin
          failures++;
          $display("FAIL mid_data got sop=%b eop=%b data=%h expected %h", sop, eop, dataOut, exp);
        end
        n++;
      end
      if (n < 3) @(negedge clk);
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL mid_start got %0d transfers expected 3", n); end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if (DVO !== 1'b0 || frames_ready !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset got DVO=%b frames_ready=%0d expected 0/0", DVO, frames_ready);
    end
    rst = 0;
    sb.delete();
    write_frame(16'h0100);
    @(negedge clk);
    DVI = 0;
    for (int c = 0; c < 40 && sb.size() > 0; c++) begin
      @(negedge clk);
      if (DVO && rdy) begin
        exp = sb.pop_front();
        checks++;
        if ({sop, eop, dataOut} !== exp) begin
          failures++;
          $display("FAIL mid_new_frame got sop=%b eop=%b data=%h expected %h", sop, eop, dataOut, exp);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL mid_count got %0d left expected 0", sb.size()); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_overflow;
    test_bitrev_order;
    test_reset_midburst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
